// File: rtl/cnn_output_collector.sv
// Collects the five CNN output channels of a crop in any order, re-references
// the x/y centres to full-frame coordinates and emits one packed result per crop.
// Optional build macro: COLLECTOR_SAT_EN (saturate the x/y sums instead of wrapping).
module cnn_output_collector #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int FP_FRAC         = 0,
    parameter int Y_1             = 10,
    parameter int X_1             = 10,
    parameter int NUM_CROPS       = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_0_TDATA,
    input  logic                         cnn_output_0_TVALID,
    output logic                         cnn_output_0_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_1_TDATA,
    input  logic                         cnn_output_1_TVALID,
    output logic                         cnn_output_1_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_2_TDATA,
    input  logic                         cnn_output_2_TVALID,
    output logic                         cnn_output_2_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_3_TDATA,
    input  logic                         cnn_output_3_TVALID,
    output logic                         cnn_output_3_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_4_TDATA,
    input  logic                         cnn_output_4_TVALID,
    output logic                         cnn_output_4_TREADY,
    output logic [5*PIXEL_BIT_WIDTH-1:0] result_TDATA,
    output logic                         result_TVALID,
    input  logic                         result_TREADY,
    output logic                         result_TLAST,
    output logic                         ap_done,
    output logic                         ap_idle
);
    localparam int W = PIXEL_BIT_WIDTH;
    localparam logic [W:0] X_OFF = (W+1)'(X_1 << FP_FRAC);
    localparam logic [W:0] Y_OFF = (W+1)'(Y_1 << FP_FRAC);
    localparam logic [7:0] LAST_IDX = 8'(NUM_CROPS - 1);

    typedef enum logic [0:0] {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;

    state_t         state_r;
    logic [4:0]     got_r;
    logic [4:0]     ready_r;
    logic [W-1:0]   hold_r [5];
    logic [7:0]     cnt_r;
    logic [5*W-1:0] data_r;
    logic           valid_r;
    logic           last_r;
    logic           done_r;
    logic           idle_r;

    logic [W-1:0]   in_data_s [5];
    logic [4:0]     in_valid_s;
    logic [4:0]     hs_s;
    logic [4:0]     got_next_s;
    logic [W-1:0]   cap_s [5];

    // Sign-extended add of the crop origin; overflow handling is build-selectable.
    function automatic logic [W-1:0] add_offset(input logic [W-1:0] v, input logic [W:0] off);
        logic [W:0] sum;
        sum = {v[W-1], v} + off;
`ifdef COLLECTOR_SAT_EN
        if (sum[W] != sum[W-1]) begin
            return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            return sum[W-1:0];
        end
`else
        return sum[W-1:0];
`endif
    endfunction

    assign in_data_s[0] = cnn_output_0_TDATA;
    assign in_data_s[1] = cnn_output_1_TDATA;
    assign in_data_s[2] = cnn_output_2_TDATA;
    assign in_data_s[3] = cnn_output_3_TDATA;
    assign in_data_s[4] = cnn_output_4_TDATA;
    assign in_valid_s   = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                           cnn_output_1_TVALID, cnn_output_0_TVALID};

    // Ready is held low while reset is asserted, independent of the register value.
    assign cnn_output_0_TREADY = ready_r[0] & ~ap_rst;
    assign cnn_output_1_TREADY = ready_r[1] & ~ap_rst;
    assign cnn_output_2_TREADY = ready_r[2] & ~ap_rst;
    assign cnn_output_3_TREADY = ready_r[3] & ~ap_rst;
    assign cnn_output_4_TREADY = ready_r[4] & ~ap_rst;
    assign result_TDATA  = data_r;
    assign result_TVALID = valid_r;
    assign result_TLAST  = last_r;
    assign ap_done       = done_r;
    assign ap_idle       = idle_r;

    // Capture view including handshakes that land in the current cycle.
    always_comb begin
        hs_s       = in_valid_s & ready_r;
        got_next_s = got_r | hs_s;
        for (int k = 0; k < 5; k++) begin
            if (hs_s[k]) begin
                cap_s[k] = in_data_s[k];
            end else begin
                cap_s[k] = hold_r[k];
            end
        end
    end

    // Collect/output sequencer with all outputs registered.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= COLLECT;
            got_r   <= 5'b00000;
            ready_r <= 5'b11111;
            cnt_r   <= 8'd0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            idle_r  <= 1'b1;
            for (int k = 0; k < 5; k++) hold_r[k] <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                COLLECT: begin
                    got_r <= got_next_s;
                    for (int k = 0; k < 5; k++) hold_r[k] <= cap_s[k];
                    if (&got_next_s) begin
                        state_r <= OUTPUT;
                        data_r  <= {cap_s[4], cap_s[3], add_offset(cap_s[2], Y_OFF),
                                    add_offset(cap_s[1], X_OFF), cap_s[0]};
                        valid_r <= 1'b1;
                        last_r  <= (cnt_r == LAST_IDX);
                        ready_r <= 5'b00000;
                        idle_r  <= 1'b0;
                    end else begin
                        ready_r <= ~got_next_s;
                        idle_r  <= (got_next_s == 5'b00000);
                    end
                end
                OUTPUT: begin
                    if (result_TREADY) begin
                        state_r <= COLLECT;
                        got_r   <= 5'b00000;
                        ready_r <= 5'b11111;
                        idle_r  <= 1'b1;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        done_r  <= last_r;
                        cnt_r   <= last_r ? 8'd0 : cnt_r + 8'd1;
                    end else begin
                        state_r <= OUTPUT;
                    end
                end
                default: begin
                    state_r <= COLLECT;
                    got_r   <= 5'b00000;
                    ready_r <= 5'b11111;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    idle_r  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_output_collector.sv
// Directed bench for cnn_output_collector: one instance with three crops per frame and
// one with a single crop per frame, both driven by the same input streams.
module tb_cnn_output_collector;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    tv;
    logic [W-1:0]  td [5];
    logic          rr;
    logic [4:0]    tr, tr1;
    logic [5*W-1:0] rd, rd1;
    logic          rv, rl, done, idle;
    logic          rv1, rl1, done1, idle1;
    logic [5*W-1:0] held;
    logic [W-1:0]  sat_exp;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    cnn_output_collector #(.PIXEL_BIT_WIDTH(W), .FP_FRAC(0), .Y_1(10), .X_1(10), .NUM_CROPS(3)) dut (
        .ap_clk(clk), .ap_rst(rst),
        .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(tr[0]),
        .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(tr[1]),
        .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(tr[2]),
        .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(tr[3]),
        .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(tr[4]),
        .result_TDATA(rd), .result_TVALID(rv), .result_TREADY(rr), .result_TLAST(rl),
        .ap_done(done), .ap_idle(idle)
    );

    cnn_output_collector #(.PIXEL_BIT_WIDTH(W), .FP_FRAC(0), .Y_1(10), .X_1(10), .NUM_CROPS(1)) dut1 (
        .ap_clk(clk), .ap_rst(rst),
        .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(tr1[0]),
        .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(tr1[1]),
        .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(tr1[2]),
        .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(tr1[3]),
        .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(tr1[4]),
        .result_TDATA(rd1), .result_TVALID(rv1), .result_TREADY(rr), .result_TLAST(rl1),
        .ap_done(done1), .ap_idle(idle1)
    );

    function automatic logic [5*W-1:0] pack(input logic [W-1:0] a, x, y, sx, sy);
        return {sy, sx, y, x, a};
    endfunction

    task automatic check(input string tag, input logic [5*W-1:0] got, input logic [5*W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic [W-1:0] a, x, y, sx, sy);
        td[0] = a; td[1] = x; td[2] = y; td[3] = sx; td[4] = sy;
    endtask

    initial begin
`ifdef COLLECTOR_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h8004;
`endif
        rst = 1'b1; tv = 5'b00000; rr = 1'b1;
        set_data(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge clk); @(negedge clk);
        check("rst_ready", 80'(tr), 80'(5'b00000));
        check("rst_flags", 80'({rv, rl, done, idle}), 80'(4'b0001));
        check("rst_data", rd, 80'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 80'(tr), 80'(5'b11111));

        // simultaneous capture on all five channels
        set_data(16'd100, 16'd20, 16'd30, 16'd4, 16'd5); tv = 5'b11111;
        @(negedge clk);
        check("sim_valid", 80'({rv, rv1}), 80'(2'b11));
        check("sim_data", rd, pack(16'd100, 16'd30, 16'd40, 16'd4, 16'd5));
        check("sim_last", 80'({rl, rl1}), 80'(2'b01));
        check("sim_ready_low", 80'(tr), 80'(5'b00000));
        tv = 5'b00000;
        @(negedge clk);
        check("sim_done", 80'({rv, done, done1}), 80'(3'b001));
        check("sim_ready_back", 80'(tr), 80'(5'b11111));
        @(negedge clk);
        check("sim_done_pulse", 80'({done, done1}), 80'(2'b00));

        // out-of-order arrival 4,2,0,3,1 with a second beat waiting on channel 4
        td[4] = 16'd7; tv = 5'b10000;
        @(negedge clk);
        check("ooo_r4", 80'(tr), 80'(5'b01111));
        td[4] = 16'd8; td[2] = 16'd50; tv = 5'b10100;
        @(negedge clk);
        check("ooo_r42", 80'(tr), 80'(5'b01011));
        td[0] = 16'd11; tv = 5'b10101;
        @(negedge clk);
        check("ooo_r420", 80'(tr), 80'(5'b01010));
        td[3] = 16'd9; tv = 5'b11101;
        @(negedge clk);
        check("ooo_r4203", 80'(tr), 80'(5'b00010));
        td[1] = 16'd60; tv = 5'b11111;
        @(negedge clk);
        check("ooo_data", rd, pack(16'd11, 16'd70, 16'd60, 16'd9, 16'd7));
        check("ooo_valid_last", 80'({rv, rl, tr}), 80'({2'b10, 5'b00000}));
        tv = 5'b10000;
        @(negedge clk);
        check("ooo_after_hs", 80'({rv, done, tr}), 80'({2'b00, 5'b11111}));
        @(negedge clk);
        check("ooo_second_beat", 80'(tr), 80'(5'b01111));
        tv = 5'b00000;

        // output back-pressure; channel 4 already holds 8 for this crop
        set_data(16'd1, 16'd2, 16'd3, 16'd4, 16'd0); tv = 5'b01111; rr = 1'b0;
        @(negedge clk);
        check("bp_data", rd, pack(16'd1, 16'd12, 16'd13, 16'd4, 16'd8));
        check("bp_last", 80'({rv, rl}), 80'(2'b11));
        tv = 5'b00000; held = pack(16'd1, 16'd12, 16'd13, 16'd4, 16'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable", rd, held);
            check("bp_hold", 80'({rv, done, tr}), 80'({2'b10, 5'b00000}));
        end
        rr = 1'b1;
        @(negedge clk);
        check("bp_release", 80'({rv, done}), 80'(2'b01));
        @(negedge clk);
        check("bp_single", 80'({rv, done}), 80'(2'b00));

        // fourth crop: x-offset overflow and frame count restart
        set_data(16'd0, 16'h7FFA, 16'd0, 16'd0, 16'd0); tv = 5'b11111;
        @(negedge clk);
        check("sat_x", 80'(rd[2*W-1:W]), 80'(sat_exp));
        check("sat_restart_last", 80'({rv, rl}), 80'(2'b10));
        tv = 5'b00000;
        @(negedge clk);
        check("sat_no_done", 80'({rv, done}), 80'(2'b00));

        // reset after three channels are captured
        set_data(16'd9, 16'd9, 16'd9, 16'd0, 16'd0); tv = 5'b00111;
        @(negedge clk);
        tv = 5'b00000; rst = 1'b1;
        @(negedge clk);
        check("mrst_in_reset", 80'({rv, done, tr}), 80'({2'b00, 5'b00000}));
        rst = 1'b0;
        @(negedge clk);
        check("mrst_clean", 80'({rv, done, idle, tr}), 80'({3'b001, 5'b11111}));
        td[3] = 16'd4; td[4] = 16'd5; tv = 5'b11000;
        @(negedge clk);
        check("mrst_no_stale", 80'({rv, tr}), 80'({1'b0, 5'b00111}));
        td[0] = 16'd1; td[1] = 16'd2; td[2] = 16'd3; tv = 5'b00111;
        @(negedge clk);
        check("mrst_data", rd, pack(16'd1, 16'd12, 16'd13, 16'd4, 16'd5));
        check("mrst_last", 80'({rv, rl}), 80'(2'b10));
        tv = 5'b00000;
        @(negedge clk);
        check("mrst_done", 80'({rv, done, done1}), 80'(3'b001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_output_collector.md
# cnn_output_collector

Downstream stage of `crop_plus_gaussian`. It consumes the five independent CNN output streams `cnn_output_0..4` for each crop, in any arrival order. It re-references the predicted centre coordinates from crop space to full-frame space using the crop origin (`Y_1`, `X_1`). It emits one packed, back-pressured result beat per crop and pulses `ap_done` after the last crop of a frame.

## Interface
- `PIXEL_BIT_WIDTH`, 16: width W of each CNN output; signed fixed point.
- `FP_FRAC`, 0: fractional bits of each CNN output.
- `Y_1`, 10: crop origin row in the input frame (integer).
- `X_1`, 10: crop origin column in the input frame (integer).
- `NUM_CROPS`, 1: crops per frame; must be 1–255.

Ports:
- `ap_clk` in 1: single clock; all logic on its rising edge.
- `ap_rst` in 1: reset, synchronous and active-high.
- `cnn_output_k_TDATA` in W, for k = 0..4. Fields: k=0 amplitude, k=1 x-centre, k=2 y-centre, k=3 sigma_x, k=4 sigma_y.
- `cnn_output_k_TVALID` in 1, for k = 0..4: upstream beat valid.
- `cnn_output_k_TREADY` out 1, for k = 0..4: collector accepts a beat on channel k.
- `result_TDATA` out 5W: packed result, from LSB to MSB: {amp, x_abs, y_abs, sigma_x, sigma_y}. So [W-1:0] is amp and [5W-1:4W] is sigma_y.
- `result_TVALID` out 1: result beat valid.
- `result_TREADY` in 1: downstream ready.
- `result_TLAST` out 1: high on the result of the last crop of a frame (crop index NUM_CROPS-1).
- `ap_done` out 1: one-cycle pulse when the last crop's result handshakes.
- `ap_idle` out 1: high when in COLLECT with no channel captured.

## Operation
- Two states: COLLECT and OUTPUT. Reset enters COLLECT.
- Per-channel state: a capture flag `got[k]` and a W-bit holding register.
- **COLLECT state**
  - `cnn_output_k_TREADY = ~got[k]`.
  - A handshake on channel k stores TDATA and sets `got[k]`.
  - Any subset of channels may handshake in the same cycle, including all five.
- **Transition to OUTPUT**
  - Triggered on the edge where `got` becomes all ones, counting handshakes made in that same cycle.
  - On that edge the result register is loaded:
    - `x_abs = x + (X_1 << FP_FRAC)`, computed at W+1 bits.
    - `y_abs = y + (Y_1 << FP_FRAC)`, computed at W+1 bits.
    - Both are reduced to W bits per the Configuration section.
    - amp, sigma_x and sigma_y pass through unchanged.
- **OUTPUT state**
  - All `cnn_output_k_TREADY = 0`.
  - `result_TVALID = 1`.
  - `result_TDATA` and `result_TLAST` stay stable until `result_TREADY`.
  - On the result handshake: clear `got`, increment the crop counter, return to COLLECT.
  - When the crop counter equals NUM_CROPS-1: assert `result_TLAST` during the beat, wrap the counter to 0, and pulse `ap_done` in the cycle after the handshake.
- No input beat is ever dropped or overwritten. A channel that has already been captured stalls via TREADY=0.

## Timing
- Values in reset: all TREADY=0, `result_TVALID=0`, `result_TDATA=0`, `result_TLAST=0`, `ap_done=0`, `ap_idle=1`. Crop counter and `got` are cleared.
- In the first cycle after reset deassertion: TREADY=1 on all channels.
- Latency: if the final input handshake occurs in cycle N, `result_TVALID` is high in cycle N+1.
- Minimum throughput: one crop per two cycles (all five inputs in cycle N, result handshake in cycle N+1).
- Reset asserted mid-operation (partial capture, or pending result): at the next edge all state is discarded, no result is emitted, and `ap_done` is not pulsed.
- `ap_done` is registered: high exactly one cycle, in the cycle after the TLAST handshake.

## Configuration
- `COLLECTOR_SAT_EN`
  - Defined: the x/y offset sums saturate to the signed W-bit range, giving 0x7FFF or 0x8000 for W=16.
  - Undefined: the sums wrap, keeping the low W bits.
  - amp and sigma fields are unaffected in both cases.

## Test plan
- **Simultaneous capture:** W=16, FRAC=0. All five channels valid in one cycle with TDATA {100, 20, 30, 4, 5}; `result_TREADY=1`. Required: TVALID high one cycle later with fields {100, 30, 40, 4, 5}, TLAST=1, and `ap_done` pulse in the next cycle.
- **Out-of-order arrival with stall:** channels arrive in order 4, 2, 0, 3, 1 on separate cycles. Channel 4 presents a second beat while `got[4]` is set. Required: `cnn_output_4_TREADY` stays 0 until after the result handshake, and the second beat is captured for the next crop.
- **Output back-pressure:** `result_TREADY=0` for 10 cycles after TVALID. Required: TDATA stable throughout, all input TREADY=0, then one handshake only.
- **Saturation:** x=0x7FFA, X_1=10.
  - With `COLLECTOR_SAT_EN`: x_abs=0x7FFF.
  - Without: x_abs=0x8004.
- **Frame count:** NUM_CROPS=3, three full crops. Required: TLAST only on the third result and exactly one `ap_done` pulse; a fourth crop restarts the count.
- **Reset mid-operation:** assert `ap_rst` after 3 channels are captured, then supply a fresh set {1, 2, 3, 4, 5}. Required: result {1, 12, 13, 4, 5}, with no stale data.
